scan_chain_ctrl: RTL and testbench



---
 rtl/scan_chain_ctrl.sv | 154 +++++++++++++++
 tb/tb_scan_chain_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_ctrl.sv
// Serialises configuration words LSB-first into a scan flip-flop chain, CHAIN_LEN shifts per run.
// Optional readback CRC of the shifted-out bits is enabled by defining SCAN_CHAIN_CRC_EN.
module scan_chain_ctrl #(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CRC_W     = 16
) (
  input  logic              CK,
  input  logic              RSTN,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              scan_en,
  output logic              scan_in,
  output logic              scan_clk_en,
  input  logic              scan_out,
  output logic              busy,
  output logic              done,
  output logic [CRC_W-1:0]  crc
);

  localparam int unsigned CntW  = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WordW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WordW-1:0]  word_cnt_q, word_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              cfg_ready_q, cfg_ready_d;
  logic              scan_en_q, scan_en_d;
  logic              scan_clk_en_q, scan_clk_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              start_acc;
  logic [31:0]       bits_left;

  assign bits_left = 32'(bit_cnt_q);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    shreg_d    = shreg_q;
    start_acc  = 1'b0;
    if (abort) begin
      state_d = StIdle;
      shreg_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          bit_cnt_d = CntW'(CHAIN_LEN);
          shreg_d   = '0;
          if (start) begin
            state_d   = StLoad;
            start_acc = 1'b1;
          end
        end
        StLoad: begin
          if (cfg_valid && cfg_ready_q) begin
            shreg_d = cfg_data;
            // Final word may be short; its unused upper bits are never shifted.
            if (bits_left < DATA_W) word_cnt_d = WordW'(bits_left);
            else                    word_cnt_d = WordW'(DATA_W);
            state_d = StShift;
          end
        end
        StShift: begin
          bit_cnt_d  = bit_cnt_q - CntW'(1);
          word_cnt_d = word_cnt_q - WordW'(1);
          shreg_d    = shreg_q >> 1;
          if (word_cnt_q == WordW'(1)) begin
            // Clearing here keeps scan_in at 0 whenever the chain clock is off.
            shreg_d = '0;
            state_d = (bit_cnt_q == CntW'(1)) ? StDone : StLoad;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    cfg_ready_d   = (state_d == StLoad);
    scan_en_d     = (state_d == StShift);
    scan_clk_en_d = (state_d == StShift);
    busy_d        = (state_d != StIdle);
    done_d        = (state_d == StDone);
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      word_cnt_q    <= '0;
      shreg_q       <= '0;
      cfg_ready_q   <= 1'b0;
      scan_en_q     <= 1'b0;
      scan_clk_en_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      word_cnt_q    <= word_cnt_d;
      shreg_q       <= shreg_d;
      cfg_ready_q   <= cfg_ready_d;
      scan_en_q     <= scan_en_d;
      scan_clk_en_q <= scan_clk_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign cfg_ready   = cfg_ready_q;
  assign scan_en     = scan_en_q;
  assign scan_in     = shreg_q[0];
  assign scan_clk_en = scan_clk_en_q;
  assign busy        = busy_q;
  assign done        = done_q;

`ifdef SCAN_CHAIN_CRC_EN
  localparam logic [CRC_W-1:0] Poly = CRC_W'(16'h1021);

  logic [CRC_W-1:0] crc_q, crc_d;

  // MSB-first serial CRC over the bit leaving the chain on each shift edge.
  always_comb begin
    crc_d = crc_q;
    if (start_acc) begin
      crc_d = '1;
    end else if (scan_clk_en_q) begin
      crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ ((crc_q[CRC_W-1] ^ scan_out) ? Poly : '0);
    end
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) crc_q <= '1;
    else       crc_q <= crc_d;
  end

  assign crc = crc_q;
`else
  logic unused_crc_inputs;
  assign unused_crc_inputs = scan_out ^ start_acc;
  assign crc = '1;
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Scoreboard bench for scan_chain_ctrl with CHAIN_LEN=10, DATA_W=4 and a behavioural chain model.
module tb_scan_chain_ctrl;

  localparam int unsigned ChainLen = 10;
  localparam int unsigned DataW    = 4;
  localparam int unsigned CrcW     = 16;

  logic              CK = 1'b0;
  logic              RSTN = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [DataW-1:0]  cfg_data = '0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready, scan_en, scan_in, scan_clk_en, scan_out, busy, done;
  logic [CrcW-1:0]   crc;

  logic [ChainLen-1:0] chain = '0;
  logic [CrcW-1:0]     crc_m = '1;
  logic [ChainLen-1:0] chain_exp;
  logic [DataW-1:0]    words [3] = '{4'hA, 4'h5, 4'h3};
  bit                  exp_q [$];
  int                  n_cmp = 0;
  int                  n_bad = 0;

  always #5 CK = ~CK;

  scan_chain_ctrl #(
    .CHAIN_LEN(ChainLen),
    .DATA_W   (DataW),
    .CRC_W    (CrcW)
  ) dut (
    .CK         (CK),
    .RSTN       (RSTN),
    .start      (start),
    .abort      (abort),
    .cfg_data   (cfg_data),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .scan_en    (scan_en),
    .scan_in    (scan_in),
    .scan_clk_en(scan_clk_en),
    .scan_out   (scan_out),
    .busy       (busy),
    .done       (done),
    .crc        (crc)
  );

  function automatic logic [CrcW-1:0] crc_step(input logic [CrcW-1:0] c, input logic b);
    return {c[CrcW-2:0], 1'b0} ^ ((c[CrcW-1] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  // chain[0] is the last flop; the earliest bit shifted in ends up there.
  assign scan_out = chain[0];

  always @(posedge CK) begin
    if (scan_clk_en) begin
      chain <= {scan_in, chain[ChainLen-1:1]};
      crc_m <= crc_step(crc_m, chain[0]);
    end
    if (RSTN && start && !busy && !abort) crc_m <= '1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_crc(input string tag);
`ifdef SCAN_CHAIN_CRC_EN
    check_eq(tag, 32'(crc), 32'(crc_m));
`else
    check_eq(tag, 32'(crc), 32'hFFFF);
`endif
  endtask

  // One programming run. stop_at > 0 interrupts on that shift with abort (or reset if use_rst).
  task automatic do_run(input int gap, input int stop_at, input bit use_rst,
                        input bit poke_start, input bit check_chain);
    int shifts = 0;
    int dones = 0;
    int widx = 0;
    int rem = ChainLen;
    int gapc = 0;
    int nb;
    bit fin = 0;
    exp_q.delete();
    @(negedge CK);
    start = 1'b1;
    @(negedge CK);
    start = 1'b0;
    check_eq("busy_at_load", 32'(busy), 32'd1);
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      if (scan_clk_en) begin
        shifts++;
        check_eq("scan_en_in_shift", 32'(scan_en), 32'd1);
        if (exp_q.size() == 0) check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
        else                   check_eq("scan_in", 32'(scan_in), 32'(exp_q.pop_front()));
      end
      if (done) begin
        dones++;
        fin = 1;
      end
      if (stop_at != 0 && shifts == stop_at && scan_clk_en) begin
        cfg_valid = 1'b0;
        if (use_rst) begin
          RSTN = 1'b0;
          #1;
          check_eq("rst_cfg_ready", 32'(cfg_ready), 32'd0);
          check_eq("rst_scan_en", 32'(scan_en), 32'd0);
          check_eq("rst_scan_in", 32'(scan_in), 32'd0);
          check_eq("rst_scan_clk_en", 32'(scan_clk_en), 32'd0);
          check_eq("rst_busy", 32'(busy), 32'd0);
          check_eq("rst_done", 32'(done), 32'd0);
          check_eq("rst_crc", 32'(crc), 32'hFFFF);
          @(negedge CK);
          RSTN = 1'b1;
        end else begin
          abort = 1'b1;
          @(negedge CK);
          abort = 1'b0;
          check_eq("abort_busy", 32'(busy), 32'd0);
          check_eq("abort_scan_en", 32'(scan_en), 32'd0);
          check_eq("abort_scan_clk_en", 32'(scan_clk_en), 32'd0);
          check_eq("abort_cfg_ready", 32'(cfg_ready), 32'd0);
          repeat (4) begin
            @(negedge CK);
            check_eq("abort_no_done", 32'(done), 32'd0);
          end
        end
        return;
      end
      start = poke_start && (shifts == 3);
      if (widx == 2 && gapc < gap && (cfg_ready || gapc > 0)) begin
        check_eq("gap_cfg_ready", 32'(cfg_ready), 32'd1);
        check_eq("gap_scan_clk_en", 32'(scan_clk_en), 32'd0);
        gapc++;
        cfg_valid = 1'b0;
      end else if (widx < 3) begin
        cfg_valid = 1'b1;
        cfg_data  = words[widx];
      end else begin
        cfg_valid = 1'b0;
      end
      if (cfg_valid && cfg_ready) begin
        nb = (rem < int'(DataW)) ? rem : int'(DataW);
        for (int i = 0; i < nb; i++) exp_q.push_back(words[widx][i]);
        widx++;
        rem -= nb;
      end
      @(negedge CK);
    end
    start = 1'b0;
    cfg_valid = 1'b0;
    check_eq("run_finished", 32'(fin), 32'd1);
    check_eq("shift_count", 32'(shifts), 32'(ChainLen));
    check_eq("done_count", 32'(dones), 32'd1);
    check_eq("sb_leftover", 32'(exp_q.size()), 32'd0);
    if (check_chain) check_eq("chain_contents", 32'(chain), 32'(chain_exp));
    check_eq("done_one_cycle", 32'(done), 32'd0);
    check_eq("idle_after_done", 32'(busy), 32'd0);
    check_crc("crc_after_run");
  endtask

  initial begin
    chain_exp = 10'b1101011010;
    repeat (3) @(negedge CK);
    check_eq("reset_cfg_ready", 32'(cfg_ready), 32'd0);
    check_eq("reset_scan_en", 32'(scan_en), 32'd0);
    check_eq("reset_scan_in", 32'(scan_in), 32'd0);
    check_eq("reset_scan_clk_en", 32'(scan_clk_en), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    check_eq("reset_crc", 32'(crc), 32'hFFFF);
    RSTN = 1'b1;

    // abort beats start in IDLE
    @(negedge CK);
    start = 1'b1;
    abort = 1'b1;
    @(negedge CK);
    start = 1'b0;
    abort = 1'b0;
    check_eq("abort_start_busy", 32'(busy), 32'd0);
    check_eq("abort_start_ready", 32'(cfg_ready), 32'd0);

    do_run(0, 0, 1'b0, 1'b0, 1'b1);  // continuous valid
    do_run(5, 0, 1'b0, 1'b0, 1'b1);  // 5-cycle gap before word 2
    do_run(0, 6, 1'b0, 1'b0, 1'b0);  // abort on 6th shift
    do_run(0, 0, 1'b0, 1'b0, 1'b1);
    do_run(0, 6, 1'b1, 1'b0, 1'b0);  // reset on 6th shift
    do_run(0, 0, 1'b0, 1'b0, 1'b1);
    do_run(0, 0, 1'b0, 1'b1, 1'b1);  // start pulsed mid-run

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
